cpu5_dmem_resp: RTL
===================

# cpu5_dmem_resp

Data-memory responder for the cpu5 core: the target end of the load/store port that the datapath drives with an address, store data and a write flag. Adds a valid/ready request and response handshake, byte/half/word access with load sign/zero extension, misalignment and decode error reporting, and two memory-mapped registers: a `tohost` mailbox and a free-running cycle counter. It sits between the core's memory stage and a word-organised single-port RAM held inside this block.

## Interface
- `XLEN`, 32, data and address width
- `DEPTH_LOG2`, 10, log2 of RAM depth in words (default 1024 words = 4 KiB)
- `clk`  in  1  the block's single clock; all state updates on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  request accepted this cycle when `req_valid && req_ready`
- `req_we`  in  1  1 = store, 0 = load
- `req_addr`  in  XLEN  byte address
- `req_wdata`  in  XLEN  store data, right-aligned (byte in [7:0], half in [15:0])
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal
- `req_unsigned`  in  1  loads only: 1 zero-extends, 0 sign-extends
- `resp_valid`  out  1  response present
- `resp_ready`  in  1  response consumed when `resp_valid && resp_ready`
- `resp_rdata`  out  XLEN  load result, already extended; 0 for stores and errors
- `resp_err`  out  1  request was misaligned, illegal size, or unmapped
- `tohost`  out  XLEN  last value stored to the mailbox
- `tohost_valid`  out  1  one-cycle pulse on each accepted mailbox store

## Operation
- Address map: RAM at 0 to 4*2^DEPTH_LOG2-1; `tohost` at 0x8000_0000 (read/write, word only); cycle counter at 0x8000_0004 (read-only, word only); all other addresses are unmapped and return an error.
- FSM has 2 states. IDLE: `req_ready`=1, `resp_valid`=0. RESP: `resp_valid`=1, with `resp_rdata`/`resp_err` held stable until the response is consumed.
- IDLE to RESP on accept. In RESP, a consumed response moves the FSM to IDLE, or holds it in RESP if a new request is accepted in the same cycle.
- `req_ready` = IDLE, or (RESP and `resp_ready`). This gives back-to-back throughput of one request per cycle.
- Alignment: a half at addr[0]=1, or a word at addr[1:0]!=0, is an error. Size 11 is an error.
- An error response has `resp_err`=1 and `resp_rdata`=0. No RAM, `tohost` or other state changes.
- Stores: the RAM word index is addr[DEPTH_LOG2+1:2]. Byte strobes are derived from size and addr[1:0], and data is replicated across lanes. Only the strobed bytes are written, at the accept edge. The store response is an ack: `resp_rdata`=0, `resp_err`=0.
- Loads: the RAM is read synchronously at the accept edge. The lane is selected by the registered addr[1:0] and size, then sign- or zero-extended per the registered `req_unsigned`.
- Loads must return data written by a store accepted in an earlier cycle.
- Stores to the cycle counter are errors.
- A half or byte access to either register is an error.
- Cycle counter: 32-bit, increments every cycle after reset, wraps 0xFFFF_FFFF to 0. A load returns the value present in the accept cycle.
- `tohost` store: the register updates at the accept edge, and `tohost_valid` is 1 for exactly the following cycle, aligned with that response's first `resp_valid` cycle.

## Timing
- Reset values: FSM IDLE, `req_ready`=1 after the reset cycle, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `tohost`=0, `tohost_valid`=0, counter 0.
- `req_ready` is 0 during the reset cycle itself.
- RAM contents are not reset.
- Latency: response valid 1 cycle after accept, with no wait states. A stalled response (`resp_ready`=0) holds all resp outputs unchanged indefinitely.
- Reset mid-operation has priority. A pending response is dropped, and a request presented during reset is not accepted, so no write occurs.
- `req_*` inputs are sampled only on accept and need not be held after it.
- A simultaneous accept and consume is legal every cycle.

## Test plan
- Word store then load: store 0xDEADBEEF to 0x10, then load a word from 0x10 → ack with err=0, then rdata=0xDEADBEEF one cycle after accept.
- Sub-word loads from that word:
  - signed byte at 0x13 → 0xFFFFFFDE
  - unsigned byte at 0x13 → 0x000000DE
  - signed half at 0x10 → 0xFFFFBEEF
  - byte store of 0x55 to 0x11, then word load of 0x10 → 0xDEAD55EF
- Errors, each followed by a word load of 0x10 that must return an unchanged value:
  - word store to 0x12 → err=1, rdata=0, RAM unchanged
  - size 11 → err=1
  - load of 0x4000_0000 → err=1
  - store to 0x8000_0004 → err=1
- Mailbox: word store 0x1 to 0x8000_0000 → `tohost`=1 and `tohost_valid` high for exactly one cycle. A half store to 0x8000_0000 → err=1, `tohost` stays 1.
- Backpressure and throughput:
  - hold `resp_ready`=0 for 5 cycles on a load → outputs stable and `req_ready`=0 throughout
  - with `resp_ready`=1, issue 8 back-to-back loads → 8 consecutive responses, one per cycle, in order
- Counter and reset:
  - two counter loads issued N cycles apart differ by N
  - assert `reset` while a response is stalled → `resp_valid`=0 the next cycle, and a request held during reset produces no write
  - counter reads restart from a small value

Source files
------------

// File: rtl/cpu5_dmem_resp.sv
// cpu5_dmem_resp: load/store target for the cpu5 memory stage.
// Word-organised RAM with byte strobes, a tohost mailbox and a cycle counter,
// behind a valid/ready request and response handshake.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | no response outstanding, ready for a request
// S_RESP | response presented; a new request is taken only as it is consumed
module cpu5_dmem_resp #(
    parameter int XLEN       = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic [XLEN-1:0] tohost,
    output logic            tohost_valid
);

    localparam int              NWORDS      = 1 << DEPTH_LOG2;
    localparam logic [XLEN-1:0] TOHOST_ADDR = XLEN'(32'h8000_0000);
    localparam logic [XLEN-1:0] CYCLE_ADDR  = XLEN'(32'h8000_0004);

    typedef enum logic {S_IDLE, S_RESP} state_t;
    // Where the response data comes from: nothing, the RAM read port, or a latched word.
    typedef enum logic [1:0] {SRC_ZERO, SRC_RAM, SRC_WORD} src_t;

    state_t          state_q, state_d;
    src_t            src_q, src_d;
    logic            err_q, err_d;
    logic [1:0]      lo_q, lo_d;
    logic [1:0]      size_q, size_d;
    logic            uns_q, uns_d;
    logic [XLEN-1:0] word_q, word_d;
    logic [XLEN-1:0] tohost_q, tohost_d;
    logic            tohost_valid_q, tohost_valid_d;
    logic [31:0]     cycle_q, cycle_d;

    logic                  accept;
    logic                  is_ram, is_tohost, is_cycle;
    logic                  bad_size, misaligned, reg_bad, req_err;
    logic [3:0]            wstrb;
    logic [XLEN-1:0]       wdata_rep;
    logic                  ram_we;
    logic [DEPTH_LOG2-1:0] ram_idx;
    logic [XLEN-1:0]       ram_rdata_q;
    logic [XLEN-1:0]       mem [NWORDS];
    logic [XLEN-1:0]       lane, ext;

    // Ready while idle or while the outstanding response is being consumed; never in reset.
    always_comb begin
        req_ready = !reset && ((state_q == S_IDLE) || resp_ready);
        accept    = req_valid && req_ready;
    end

    // Address decode and error classification of the incoming request.
    always_comb begin
        is_ram     = (req_addr >> (DEPTH_LOG2 + 2)) == '0;
        is_tohost  = req_addr == TOHOST_ADDR;
        is_cycle   = req_addr == CYCLE_ADDR;
        bad_size   = req_size == 2'b11;
        misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                     ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
        // Registers are word-only, and the counter is read-only.
        reg_bad    = (is_tohost || is_cycle) && ((req_size != 2'b10) || (is_cycle && req_we));
        req_err    = bad_size || misaligned || !(is_ram || is_tohost || is_cycle) || reg_bad;
    end

    // Byte strobes from size/offset, with store data replicated across all lanes.
    always_comb begin
        wstrb     = 4'b0000;
        wdata_rep = req_wdata;
        case (req_size)
            2'b00: begin
                wstrb     = 4'b0001 << req_addr[1:0];
                wdata_rep = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                wstrb     = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{req_wdata[15:0]}};
            end
            2'b10:   wstrb = 4'b1111;
            default: wstrb = 4'b0000;
        endcase
        ram_we  = accept && req_we && !req_err && is_ram;
        ram_idx = req_addr[DEPTH_LOG2+1:2];
    end

    // RAM port: strobed write and synchronous read, both on the accept edge; contents not reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) mem[ram_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
            end
        end
        if (accept && !req_we) ram_rdata_q <= mem[ram_idx];
    end

    // Next-state: capture the request on accept, retire the response when consumed.
    always_comb begin
        state_d        = state_q;
        src_d          = src_q;
        err_d          = err_q;
        lo_d           = lo_q;
        size_d         = size_q;
        uns_d          = uns_q;
        word_d         = word_q;
        tohost_d       = tohost_q;
        tohost_valid_d = 1'b0;
        cycle_d        = cycle_q + 32'd1;
        if (accept) begin
            state_d = S_RESP;
            err_d   = req_err;
            lo_d    = req_addr[1:0];
            size_d  = req_size;
            uns_d   = req_unsigned;
            src_d   = SRC_ZERO;
            word_d  = '0;
            if (!req_err && !req_we) begin
                if (is_ram) begin
                    src_d = SRC_RAM;
                end else begin
                    src_d  = SRC_WORD;
                    word_d = is_tohost ? tohost_q : cycle_q;
                end
            end
            if (!req_err && req_we && is_tohost) begin
                tohost_d       = req_wdata;
                tohost_valid_d = 1'b1;
            end
        end else if ((state_q == S_RESP) && resp_ready) begin
            state_d = S_IDLE;
        end
    end

    // State and response registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            src_q          <= SRC_ZERO;
            err_q          <= 1'b0;
            lo_q           <= 2'b00;
            size_q         <= 2'b00;
            uns_q          <= 1'b0;
            word_q         <= '0;
            tohost_q       <= '0;
            tohost_valid_q <= 1'b0;
            cycle_q        <= '0;
        end else begin
            state_q        <= state_d;
            src_q          <= src_d;
            err_q          <= err_d;
            lo_q           <= lo_d;
            size_q         <= size_d;
            uns_q          <= uns_d;
            word_q         <= word_d;
            tohost_q       <= tohost_d;
            tohost_valid_q <= tohost_valid_d;
            cycle_q        <= cycle_d;
        end
    end

    // Lane select and extension of the RAM word; only registered inputs, so stable under stall.
    always_comb begin
        lane = ram_rdata_q >> {lo_q, 3'b000};
        case (size_q)
            2'b00:   ext = uns_q ? {24'b0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
            2'b01:   ext = uns_q ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
            default: ext = lane;
        endcase
        case (src_q)
            SRC_RAM:  resp_rdata = ext;
            SRC_WORD: resp_rdata = word_q;
            default:  resp_rdata = '0;
        endcase
    end

    assign resp_valid   = (state_q == S_RESP);
    assign resp_err     = err_q;
    assign tohost       = tohost_q;
    assign tohost_valid = tohost_valid_q;

endmodule
